// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
// Match modes and the length clamp/mask functions used by seq_detector_param.
package seq_det_pkg;

   localparam logic MODE_NONOVL = 1'b0;
   localparam logic MODE_OVL    = 1'b1;
   localparam int   MAX_W_LIMIT = 32;

   // Mask of the low len bits; len >= 32 yields all ones.
   function automatic logic [MAX_W_LIMIT-1:0] len_mask(input int len);
      logic [MAX_W_LIMIT-1:0] m;
      if (len >= MAX_W_LIMIT) m = '1;
      else                    m = (32'd1 << len) - 32'd1;
      return m;
   endfunction

   function automatic int clamp_len(input int len, input int max_w);
      int l;
      if (len < 1)          l = 1;
      else if (len > max_w) l = max_w;
      else                  l = len;
      return l;
   endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Used for the optional match counter.
module seq_det_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          r_cnt <= '0;
      else if (i_clr)                   r_cnt <= '0;
      else if (i_inc && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time loadable serial-pattern detector with overlap mode and input qualifier.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt output.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               MAX_W       = 8,
   parameter logic [MAX_W-1:0] DEF_PATTERN = 8'h0B,
   parameter int               DEF_LEN     = 4,
   parameter int               CNT_W       = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inp_valid,
   input  logic                       inp,
   input  logic                       pat_load,
   input  logic [MAX_W-1:0]           pat_in,
   input  logic [$clog2(MAX_W+1)-1:0] pat_len,
   input  logic                       overlap,
   output logic                       out
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [CNT_W-1:0]           match_cnt
`endif
);

   localparam int             LW       = $clog2(MAX_W+1);
   localparam logic [LW-1:0]  FILL_MAX = LW'(MAX_W);
   localparam logic [LW-1:0]  RST_LEN  = LW'(clamp_len(DEF_LEN, MAX_W));

   logic [MAX_W-1:0] r_pattern;
   logic [MAX_W-1:0] r_hist;
   logic [LW-1:0]    r_len;
   logic [LW-1:0]    r_fill;
   logic             r_out;

   logic [MAX_W-1:0] w_mask;
   logic [MAX_W-1:0] w_hist_n;
   logic [LW-1:0]    w_fill_n;
   logic [LW-1:0]    w_load_len;
   logic             w_accept;
   logic             w_hit;

   assign w_mask     = MAX_W'(len_mask(int'(r_len)));
   assign w_load_len = LW'(clamp_len(int'(pat_len), MAX_W));
   assign w_accept   = inp_valid & ~pat_load;
   assign w_hist_n   = (r_hist << 1) | {{(MAX_W-1){1'b0}}, inp};
   assign w_fill_n   = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
   // fill gates the compare so stale zeros after reset/load never form a match
   assign w_hit      = w_accept && (w_fill_n >= r_len) &&
                       (((w_hist_n ^ r_pattern) & w_mask) == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pattern <= DEF_PATTERN;
         r_len     <= RST_LEN;
         r_hist    <= '0;
         r_fill    <= '0;
         r_out     <= 1'b0;
      end else if (pat_load) begin
         r_pattern <= pat_in;
         r_len     <= w_load_len;
         r_hist    <= '0;
         r_fill    <= '0;
         r_out     <= 1'b0;
      end else if (inp_valid) begin
         r_hist <= w_hist_n;
         r_fill <= (w_hit && (overlap == MODE_NONOVL)) ? '0 : w_fill_n;
         r_out  <= w_hit;
      end else begin
         r_out  <= 1'b0;
      end
   end

   assign out = r_out;

`ifdef SEQ_DET_COUNT_EN
   seq_det_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_inc (w_hit),
      .i_clr (pat_load),
      .o_cnt (match_cnt)
   );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default pattern, overlap modes,
// valid gaps, run-time loads with length clamping, and async reset.
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       inp_valid, inp, pat_load, overlap;
   logic [7:0] pat_in;
   logic [3:0] pat_len;
   logic       out;
`ifdef SEQ_DET_COUNT_EN
   logic [15:0] match_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   seq_detector_param dut (
      .clk       (clk),
      .rst       (rst),
      .inp_valid (inp_valid),
      .inp       (inp),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .pat_len   (pat_len),
      .overlap   (overlap),
      .out       (out)
`ifdef SEQ_DET_COUNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );

   always #5 clk = ~clk;

   // One clock: drive at negedge, sample 1 time unit after the rising edge.
   task automatic drive(input logic v, input logic b, input logic ld);
      @(negedge clk);
      inp_valid = v;
      inp       = b;
      pat_load  = ld;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; inp_valid = 1'b0; inp = 1'b0; pat_load = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_chk++;
      if (out !== 1'b0) $display("FAIL reset_out: got %b want 0", out);
      else n_pass++;
`ifdef SEQ_DET_COUNT_EN
      n_chk++;
      if (match_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", match_cnt);
      else n_pass++;
`endif
      do_reset();
   endtask

   task automatic test_overlap();
      logic [6:0] bits = 7'b1011011;
      logic [6:0] exp  = 7'b0001001;
      do_reset();
      overlap = 1'b1;
      for (int i = 6; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_chk++;
         if (out !== exp[i]) $display("FAIL overlap_bit%0d: got %b want %b", 7-i, out, exp[i]);
         else n_pass++;
      end
`ifdef SEQ_DET_COUNT_EN
      n_chk++;
      if (match_cnt !== 16'd2) $display("FAIL overlap_cnt: got %0d want 2", match_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_nonoverlap();
      logic [10:0] bits = 11'b1011011_1011;
      logic [10:0] exp  = 11'b0001000_0001;
      do_reset();
      overlap = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_chk++;
         if (out !== exp[i]) $display("FAIL nonovl_bit%0d: got %b want %b", 11-i, out, exp[i]);
         else n_pass++;
      end
`ifdef SEQ_DET_COUNT_EN
      n_chk++;
      if (match_cnt !== 16'd2) $display("FAIL nonovl_cnt: got %0d want 2", match_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_valid_gaps();
      logic [6:0] v   = 7'b1011010;
      logic [6:0] b   = 7'b1101110;
      logic [6:0] exp = 7'b0000010;
      do_reset();
      overlap = 1'b1;
      for (int i = 6; i >= 0; i--) begin
         drive(v[i], b[i], 1'b0);
         n_chk++;
         if (out !== exp[i]) $display("FAIL gaps_step%0d: got %b want %b", 7-i, out, exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_load_len1();
      do_reset();
      overlap = 1'b1;
      pat_in = 8'h00; pat_len = 4'd1;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         n_chk++;
         if (out !== 1'b1) $display("FAIL len1_zero%0d: got %b want 1", i, out);
         else n_pass++;
      end
      drive(1'b1, 1'b1, 1'b0);
      n_chk++;
      if (out !== 1'b0) $display("FAIL len1_one: got %b want 0", out);
      else n_pass++;
      // length 0 clamps to 1
      pat_in = 8'h01; pat_len = 4'd0;
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      n_chk++;
      if (out !== 1'b1) $display("FAIL len0_hit: got %b want 1", out);
      else n_pass++;
      drive(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (out !== 1'b0) $display("FAIL len0_miss: got %b want 0", out);
      else n_pass++;
      // length 12 clamps to 8: eight ones are needed
      pat_in = 8'hFF; pat_len = 4'd12;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b1, 1'b0);
         n_chk++;
         if (out !== (i == 8)) $display("FAIL len12_bit%0d: got %b want %b", i, out, (i == 8));
         else n_pass++;
      end
   endtask

   task automatic test_load_discard();
      logic [7:0] pat = 8'hA5;
      do_reset();
      overlap = 1'b1;
      pat_in = 8'hA5; pat_len = 4'd8;
      drive(1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 1; i--) drive(1'b1, pat[i], 1'b0);
      drive(1'b1, pat[0], 1'b1);
      n_chk++;
      if (out !== 1'b0) $display("FAIL load_wins: got %b want 0", out);
      else n_pass++;
      for (int i = 7; i >= 0; i--) begin
         drive(1'b1, pat[i], 1'b0);
         n_chk++;
         if (out !== (i == 0)) $display("FAIL a5_bit%0d: got %b want %b", 8-i, out, (i == 0));
         else n_pass++;
      end
`ifdef SEQ_DET_COUNT_EN
      n_chk++;
      if (match_cnt !== 16'd1) $display("FAIL a5_cnt: got %0d want 1", match_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_async_reset();
      logic [5:0] bits = 6'b111011;
      logic [5:0] exp  = 6'b000001;
      do_reset();
      overlap = 1'b1;
      pat_in = 8'h00; pat_len = 4'd1;
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (out !== 1'b1) $display("FAIL prerst_out: got %b want 1", out);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_chk++;
      if (out !== 1'b0) $display("FAIL async_out: got %b want 0", out);
      else n_pass++;
`ifdef SEQ_DET_COUNT_EN
      n_chk++;
      if (match_cnt !== 16'd0) $display("FAIL async_cnt: got %0d want 0", match_cnt);
      else n_pass++;
`endif
      @(negedge clk);
      rst = 1'b0; inp_valid = 1'b0; pat_load = 1'b0;
      // 1,0 then reset mid-pattern: the trailing 1,1 must not complete 1011
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         drive(1'b1, bits[i], 1'b0);
         n_chk++;
         if (out !== exp[i]) $display("FAIL rst_resume%0d: got %b want %b", 6-i, out, exp[i]);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; inp_valid = 1'b0; inp = 1'b0; pat_load = 1'b0;
      overlap = 1'b1; pat_in = 8'h00; pat_len = 4'd0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_valid_gaps();
      test_load_len1();
      test_load_discard();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
